// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, ALU opcodes and helpers for decode and ALU.
// Used by decode_stage; see decode_comb for the ILLEGAL_INSN_EN option.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_VALUE = 32'h0000_0013;
    localparam logic [6:0]  F7_BASE   = 7'b0000000;
    localparam logic [6:0]  F7_ALT    = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_sel_e;

    typedef struct packed {
        alu_sel_e    alu_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        a_is_pc;
        logic        b_is_imm;
        logic        reg_we;
        logic        illegal;
    } dec_t;

    function automatic alu_sel_e alu_of(input logic [2:0] f3, input logic alt);
        alu_sel_e s;
        unique case (f3)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

    // funct7 only constrains OP and the OP-IMM shifts; elsewhere it is immediate.
    function automatic logic insn_legal(input logic [31:0] insn);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ok;
        opc = insn[6:0];
        f7  = insn[31:25];
        f3  = insn[14:12];
        ok  = 1'b0;
        if (opc == OPC_OP) begin
            ok = (f7 == F7_BASE)
              || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        end else if (opc == OPC_OP_IMM) begin
            if (f3 == 3'b001)
                ok = (f7 == F7_BASE);
            else if (f3 == 3'b101)
                ok = (f7 == F7_BASE) || (f7 == F7_ALT);
            else
                ok = 1'b1;
        end else begin
            ok = (opc == OPC_LUI) || (opc == OPC_AUIPC);
        end
        return ok;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32 instruction -> decoded bundle.
// ILLEGAL_INSN_EN: pass illegal encodings flagged instead of substituting NOP_INSN.
module decode_comb
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_VALUE
) (
    input  logic [31:0] insn,
    output dec_t        dec
);

    logic [31:0] insn_eff;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        legal;
    logic        shift;

    always_comb begin
        insn_eff = insn;
`ifndef ILLEGAL_INSN_EN
        if (!insn_legal(insn))
            insn_eff = NOP_INSN;
`endif
    end

    assign opc   = insn_eff[6:0];
    assign f3    = insn_eff[14:12];
    assign legal = insn_legal(insn_eff);
    assign shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            legal && opc == OPC_OP: begin
                dec.alu_sel = alu_of(f3, insn_eff[30]);
                dec.rs1     = insn_eff[19:15];
                dec.rs2     = insn_eff[24:20];
                dec.rd      = insn_eff[11:7];
            end
            legal && opc == OPC_OP_IMM: begin
                dec.alu_sel  = alu_of(f3, insn_eff[30] && f3 == 3'b101);
                dec.rs1      = insn_eff[19:15];
                dec.rd       = insn_eff[11:7];
                dec.b_is_imm = 1'b1;
                dec.imm      = shift ? {27'b0, insn_eff[24:20]}
                                     : {{20{insn_eff[31]}}, insn_eff[31:20]};
            end
            legal && (opc == OPC_LUI || opc == OPC_AUIPC): begin
                dec.alu_sel  = ALU_ADD;
                dec.rd       = insn_eff[11:7];
                dec.b_is_imm = 1'b1;
                dec.a_is_pc  = (opc == OPC_AUIPC);
                dec.imm      = {insn_eff[31:12], 12'b0};
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.reg_we = legal && (dec.rd != 5'd0);
`ifndef ILLEGAL_INSN_EN
        dec.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready register around decode_comb.
// Macro ILLEGAL_INSN_EN selects illegal-instruction pass-through in decode_comb.
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_VALUE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_alu_sel,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic        out_a_is_pc,
    output logic        out_b_is_imm,
    output logic        out_reg_we,
    output logic        out_illegal
);

    dec_t        dec;
    dec_t        dec_d, dec_q;
    logic [31:0] pc_d, pc_q;
    logic        valid_d, valid_q;
    logic        accept;

    decode_comb #(.NOP_INSN(NOP_INSN)) u_comb (
        .insn (in_insn),
        .dec  (dec)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        dec_d   = dec_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            dec_d   = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_alu_sel  = dec_q.alu_sel;
    assign out_rs1      = dec_q.rs1;
    assign out_rs2      = dec_q.rs2;
    assign out_rd       = dec_q.rd;
    assign out_imm      = dec_q.imm;
    assign out_a_is_pc  = dec_q.a_is_pc;
    assign out_b_is_imm = dec_q.b_is_imm;
    assign out_reg_we   = dec_q.reg_we;
    assign out_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus random traffic.
// Build with ILLEGAL_INSN_EN defined to check the pass-through variant.
module tb_decode_stage;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_insn, in_pc, out_pc, out_imm;
    logic [3:0]  out_alu_sel;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_a_is_pc, out_b_is_imm, out_reg_we, out_illegal;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu_sel(out_alu_sel), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_imm(out_imm),
        .out_a_is_pc(out_a_is_pc), .out_b_is_imm(out_b_is_imm),
        .out_reg_we(out_reg_we), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        a, b, we, ill;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state: what the stage should be presenting
    logic        m_valid;
    logic [31:0] m_pc;
    exp_t        m_b;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_legal(input logic [31:0] i);
        logic [6:0] o;
        logic [6:0] f7;
        int         f3;
        o  = i[6:0];
        f7 = i[31:25];
        f3 = int'(i[14:12]);
        if (o == 7'h33)
            return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        if (o == 7'h13) begin
            if (f3 == 1) return f7 == 7'h00;
            if (f3 == 5) return f7 == 7'h00 || f7 == 7'h20;
            return 1'b1;
        end
        return o == 7'h37 || o == 7'h17;
    endfunction

    function automatic exp_t m_dec(input logic [31:0] i);
        exp_t       e;
        int         f3;
        logic [3:0] tbl [8];
        tbl = '{4'd1, 4'd6, 4'd9, 4'd10, 4'd3, 4'd7, 4'd4, 4'd5};
        e  = '0;
        f3 = int'(i[14:12]);
        if (!m_legal(i)) begin
`ifdef ILLEGAL_INSN_EN
            e.ill = 1'b1;
`else
            e.alu = 4'd1;
            e.b   = 1'b1;
`endif
            return e;
        end
        e.rd = i[11:7];
        if (i[6:0] == 7'h33) begin
            e.alu = tbl[f3] + ((i[30] && (f3 == 0 || f3 == 5)) ? 4'd1 : 4'd0);
            e.rs1 = i[19:15];
            e.rs2 = i[24:20];
        end else if (i[6:0] == 7'h13) begin
            e.alu = tbl[f3] + ((i[30] && f3 == 5) ? 4'd1 : 4'd0);
            e.rs1 = i[19:15];
            e.b   = 1'b1;
            if (f3 == 1 || f3 == 5)
                e.imm = 32'(i[24:20]);
            else
                e.imm = 32'($signed(i[31:20]));
        end else begin
            e.alu = 4'd1;
            e.b   = 1'b1;
            e.a   = (i[6:0] == 7'h17);
            e.imm = i[31:12] << 12;
        end
        e.we = (e.rd != 0);
        return e;
    endfunction

    task automatic compare_all();
        check("valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("pc",   out_pc,               m_pc);
            check("alu",  32'(out_alu_sel),     32'(m_b.alu));
            check("rs1",  32'(out_rs1),         32'(m_b.rs1));
            check("rs2",  32'(out_rs2),         32'(m_b.rs2));
            check("rd",   32'(out_rd),          32'(m_b.rd));
            check("imm",  out_imm,              m_b.imm);
            check("a_pc", 32'(out_a_is_pc),     32'(m_b.a));
            check("b_im", 32'(out_b_is_imm),    32'(m_b.b));
            check("we",   32'(out_reg_we),      32'(m_b.we));
            check("ill",  32'(out_illegal),     32'(m_b.ill));
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] insn,
                       input logic [31:0] pc, input logic ordy,
                       input logic fl);
        bit acc;
        @(negedge clk);
        compare_all();
        in_valid  = v;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy) && !fl;
        if (fl)        m_valid = 1'b0;
        else if (acc)  m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        if (acc) begin
            m_b  = m_dec(insn);
            m_pc = pc;
        end
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [6:0]  o, f7;
        int          s, k;
        r = $urandom;
        s = $urandom_range(0, 9);
        k = $urandom_range(0, 3);
        o  = s < 3 ? 7'h33 : s < 6 ? 7'h13 : s == 6 ? 7'h37 :
             s == 7 ? 7'h17 : r[31:25];
        f7 = k == 0 ? 7'h00 : k == 1 ? 7'h20 : 7'($urandom);
        return {f7, r[24:7], o};
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_insn = '0; in_pc = '0;
        out_ready = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_pc = '0; m_b = '0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_alu",   32'(out_alu_sel), 32'd0);
        check("rst_imm",   out_imm, 32'd0);
        check("rst_we",    32'(out_reg_we), 32'd0);
        #6 rst = 1'b0;

        cyc(1, 32'h002081B3, 32'h100, 1, 0);
        peek();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_alu",   32'(out_alu_sel), 32'd1);
        check("add_rs1",   32'(out_rs1), 32'd1);
        check("add_rs2",   32'(out_rs2), 32'd2);
        check("add_rd",    32'(out_rd), 32'd3);
        check("add_bimm",  32'(out_b_is_imm), 32'd0);
        check("add_we",    32'(out_reg_we), 32'd1);

        cyc(1, 32'hFFF00293, 32'h104, 1, 0);
        peek();
        check("addi_alu",  32'(out_alu_sel), 32'd1);
        check("addi_imm",  out_imm, 32'hFFFF_FFFF);
        check("addi_bimm", 32'(out_b_is_imm), 32'd1);
        check("addi_rd",   32'(out_rd), 32'd5);

        cyc(1, 32'h4043D313, 32'h108, 1, 0);
        peek();
        check("srai_alu", 32'(out_alu_sel), 32'd8);
        check("srai_imm", out_imm, 32'd4);

        cyc(1, 32'h123450B7, 32'h10C, 1, 0);
        peek();
        check("lui_alu", 32'(out_alu_sel), 32'd1);
        check("lui_rs1", 32'(out_rs1), 32'd0);
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_apc", 32'(out_a_is_pc), 32'd0);

        cyc(1, 32'h12345097, 32'h110, 1, 0);
        peek();
        check("auipc_imm", out_imm, 32'h1234_5000);
        check("auipc_apc", 32'(out_a_is_pc), 32'd1);

        cyc(1, 32'h0000007F, 32'h114, 1, 0);
        peek();
`ifdef ILLEGAL_INSN_EN
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_alu",  32'(out_alu_sel), 32'd0);
`else
        check("ill_flag", 32'(out_illegal), 32'd0);
        check("ill_alu",  32'(out_alu_sel), 32'd1);
        check("ill_rd",   32'(out_rd), 32'd0);
`endif
        check("ill_we", 32'(out_reg_we), 32'd0);

        // back-pressure: held bundle must not move for three cycles
        cyc(1, 32'h00510133, 32'h200, 1, 0);
        for (int n = 0; n < 3; n++)
            cyc(1, 32'h40208233, 32'h204, 0, 0);
        check("stall_rdy", 32'(in_ready), 32'd0);
        cyc(1, 32'h40208233, 32'h204, 1, 0);
        peek();
        check("stall_pc",  out_pc, 32'h204);
        check("stall_alu", 32'(out_alu_sel), 32'd2);

        cyc(1, 32'h002081B3, 32'h300, 1, 1);
        peek();
        check("flush_valid", 32'(out_valid), 32'd0);

        cyc(1, 32'h002081B3, 32'h400, 1, 0);
        cyc(1, 32'h002081B3, 32'h404, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_rd",    32'(out_rd), 32'd0);
        m_valid = 1'b0; m_pc = '0; m_b = '0;
        #1 rst = 1'b0;
        #1;
        check("rst_mid_rdy", 32'(in_ready), 32'd1);

        for (int n = 0; n < 600; n++)
            cyc(1'($urandom_range(0, 3) != 0), rand_insn(), $urandom,
                1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
        cyc(0, 32'h0, 32'h0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
